// File: rtl/free_list_if.sv
// Rename/retire handshake bundle for the physical-register free list.
// The free list itself connects through the slave modport.
interface free_list_if #(
  parameter int unsigned N_PHYS = 64,
  parameter int unsigned N_ARCH = 32
);
  localparam int unsigned TAG_W = $clog2(N_PHYS);
  localparam int unsigned FL_SZ = N_PHYS - N_ARCH;
  localparam int unsigned CNT_W = $clog2(FL_SZ) + 1;

  logic             interrupt;
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             retire_en;
  logic             retire_t_valid;
  logic [TAG_W-1:0] retire_t_old;
  logic             retire_t_old_valid;
  logic [CNT_W-1:0] free_count;
  logic             overflow_err;

  modport master (
    output interrupt, alloc_req, retire_en, retire_t_valid, retire_t_old, retire_t_old_valid,
    input  alloc_valid, alloc_tag, free_count, overflow_err
  );

  modport slave (
    input  interrupt, alloc_req, retire_en, retire_t_valid, retire_t_old, retire_t_old_valid,
    output alloc_valid, alloc_tag, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags with a speculative head
// and an architectural head that lets a flush reclaim all in-flight tags at once.
module free_list #(
  parameter int unsigned N_PHYS = 64,
  parameter int unsigned N_ARCH = 32
) (
  input  logic        clock,
  input  logic        reset,
  free_list_if.slave  fl_if
);
  localparam int unsigned TAG_W = $clog2(N_PHYS);
  localparam int unsigned FL_SZ = N_PHYS - N_ARCH;
  localparam int unsigned PTR_W = $clog2(FL_SZ);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] fl_q [FL_SZ];
  logic [TAG_W-1:0] fl_d [FL_SZ];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty;
  logic alloc_fire, free_fire, free_drop, free_wr, arch_adv;

  // Next-state computation; a flush still honours the same-cycle retire.
  always_comb begin
    fl_d        = fl_q;
    head_d      = head_q;
    arch_head_d = arch_head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    full       = (count_q == CNT_W'(FL_SZ));
    empty      = (count_q == '0);
    alloc_fire = fl_if.alloc_req && !empty && !fl_if.interrupt;
    free_fire  = fl_if.retire_en && fl_if.retire_t_old_valid;
    free_drop  = free_fire && full && !alloc_fire;
    free_wr    = free_fire && !free_drop;
    arch_adv   = fl_if.retire_en && fl_if.retire_t_valid;

    if (free_wr) begin
      fl_d[tail_q] = fl_if.retire_t_old;
      tail_d       = tail_q + PTR_W'(1);
    end
    if (free_drop) begin
      overflow_d = 1'b1;
    end
    if (arch_adv) begin
      arch_head_d = arch_head_q + PTR_W'(1);
    end

    if (fl_if.interrupt) begin
      head_d  = arch_head_d;
      count_d = CNT_W'(FL_SZ);
    end else begin
      if (alloc_fire) begin
        head_d = head_q + PTR_W'(1);
      end
      if (free_wr && !alloc_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (alloc_fire && !free_wr) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(FL_SZ); i++) begin
        fl_q[i] <= TAG_W'(int'(N_ARCH) + i);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      count_q     <= CNT_W'(FL_SZ);
      overflow_q  <= 1'b0;
    end else begin
      fl_q        <= fl_d;
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Outputs depend on registers only; dispatch sees the head tag with zero latency.
  assign fl_if.alloc_valid  = (count_q != '0);
  assign fl_if.alloc_tag    = fl_q[head_q];
  assign fl_if.free_count   = count_q;
  assign fl_if.overflow_err = overflow_q;
endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list: drain, reuse, wrap, flush and overflow cases.
module tb_free_list;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  free_list_if #(.N_PHYS(64), .N_ARCH(32)) fl_if ();

  free_list #(.N_PHYS(64), .N_ARCH(32)) dut (
    .clock (clock),
    .reset (reset),
    .fl_if (fl_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fl_if.interrupt          = 1'b0;
    fl_if.alloc_req          = 1'b0;
    fl_if.retire_en          = 1'b0;
    fl_if.retire_t_valid     = 1'b0;
    fl_if.retire_t_old       = '0;
    fl_if.retire_t_old_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("reset_valid", 32'(fl_if.alloc_valid), 1);
    chk("reset_tag", 32'(fl_if.alloc_tag), 32);
    chk("reset_count", 32'(fl_if.free_count), 32);
    chk("reset_ovf", 32'(fl_if.overflow_err), 0);

    // Reset drain: tags 32..63 in order, count 32 -> 0
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag", 32'(fl_if.alloc_tag), 32'(32 + i));
      chk("drain_count", 32'(fl_if.free_count), 32'(32 - i));
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
    chk("drain_empty_valid", 32'(fl_if.alloc_valid), 0);
    chk("drain_empty_count", 32'(fl_if.free_count), 0);
    fl_if.alloc_req = 1'b1;
    tick();
    fl_if.alloc_req = 1'b0;
    chk("req33_valid", 32'(fl_if.alloc_valid), 0);
    chk("req33_count", 32'(fl_if.free_count), 0);

    // Free and reuse when empty
    fl_if.retire_en          = 1'b1;
    fl_if.retire_t_old_valid = 1'b1;
    fl_if.retire_t_old       = 6'd5;
    tick();
    idle();
    chk("reuse_valid", 32'(fl_if.alloc_valid), 1);
    chk("reuse_tag", 32'(fl_if.alloc_tag), 5);
    chk("reuse_count", 32'(fl_if.free_count), 1);

    // Simultaneous alloc + free at full
    do_reset();
    fl_if.alloc_req          = 1'b1;
    fl_if.retire_en          = 1'b1;
    fl_if.retire_t_old_valid = 1'b1;
    fl_if.retire_t_old       = 6'd7;
    tick();
    idle();
    chk("full_af_count", 32'(fl_if.free_count), 32);
    chk("full_af_ovf", 32'(fl_if.overflow_err), 0);
    for (int i = 0; i < 31; i++) begin
      chk("full_af_tag", 32'(fl_if.alloc_tag), 32'(33 + i));
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
    chk("full_af_wrap_tag", 32'(fl_if.alloc_tag), 7);
    chk("full_af_wrap_count", 32'(fl_if.free_count), 1);

    // Flush recovery
    do_reset();
    alloc_n(10);
    chk("flush_pre_count", 32'(fl_if.free_count), 22);
    for (int i = 1; i <= 3; i++) begin
      fl_if.retire_en          = 1'b1;
      fl_if.retire_t_valid     = 1'b1;
      fl_if.retire_t_old_valid = 1'b1;
      fl_if.retire_t_old       = 6'(i);
      tick();
    end
    idle();
    chk("flush_ret_count", 32'(fl_if.free_count), 25);
    fl_if.interrupt = 1'b1;
    tick();
    idle();
    chk("flush_count", 32'(fl_if.free_count), 32);
    chk("flush_tag", 32'(fl_if.alloc_tag), 35);
    for (int i = 0; i < 32; i++) begin
      chk("flush_seq_tag", 32'(fl_if.alloc_tag), (i < 29) ? 32'(35 + i) : 32'(i - 28));
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
    chk("flush_seq_empty", 32'(fl_if.alloc_valid), 0);

    // Interrupt with same-cycle retire
    do_reset();
    alloc_n(4);
    fl_if.interrupt          = 1'b1;
    fl_if.retire_en          = 1'b1;
    fl_if.retire_t_valid     = 1'b1;
    fl_if.retire_t_old_valid = 1'b1;
    fl_if.retire_t_old       = 6'd9;
    tick();
    idle();
    chk("intret_count", 32'(fl_if.free_count), 32);
    chk("intret_tag", 32'(fl_if.alloc_tag), 33);
    for (int i = 0; i < 31; i++) begin
      chk("intret_seq_tag", 32'(fl_if.alloc_tag), 32'(33 + i));
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
    chk("intret_freed_tag", 32'(fl_if.alloc_tag), 9);

    // Overflow: free at full with no alloc
    do_reset();
    fl_if.retire_en          = 1'b1;
    fl_if.retire_t_old_valid = 1'b1;
    fl_if.retire_t_old       = 6'd4;
    tick();
    idle();
    chk("ovf_flag", 32'(fl_if.overflow_err), 1);
    chk("ovf_count", 32'(fl_if.free_count), 32);
    chk("ovf_tag", 32'(fl_if.alloc_tag), 32);
    for (int i = 0; i < 32; i++) begin
      chk("ovf_seq_tag", 32'(fl_if.alloc_tag), 32'(32 + i));
      fl_if.alloc_req = 1'b1;
      tick();
    end
    fl_if.alloc_req = 1'b0;
    chk("ovf_sticky", 32'(fl_if.overflow_err), 1);
    chk("ovf_drained", 32'(fl_if.free_count), 0);

    // Reset has priority over interrupt
    reset           = 1'b1;
    fl_if.interrupt = 1'b1;
    tick();
    reset           = 1'b0;
    fl_if.interrupt = 1'b0;
    chk("rstpri_ovf", 32'(fl_if.overflow_err), 0);
    chk("rstpri_count", 32'(fl_if.free_count), 32);
    chk("rstpri_valid", 32'(fl_if.alloc_valid), 1);
    chk("rstpri_tag", 32'(fl_if.alloc_tag), 32);
    alloc_n(1);
    chk("rstpri_next_tag", 32'(fl_if.alloc_tag), 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the R10K-style rename pipeline. Supplies the next free physical tag to dispatch, which writes it into the ROB as `t`. Reclaims the `t_old` tag that the ROB presents on its retire output. Keeps an architectural head pointer that advances only on retire, so that an interrupt/flush returns every tag allocated by squashed in-flight instructions in one cycle.

## Interface
- `N_PHYS`, 64, number of physical registers; tag width `TAG_W = $clog2(N_PHYS)`.
- `N_ARCH`, 32, number of architectural registers; physical regs `0..N_ARCH-1` are architecturally mapped at reset.
- `FL_SZ`, derived `N_PHYS - N_ARCH`, free-list depth (power of two required).
- `clock  in  1  clock` — all state updates on the rising edge.
- `reset  in  1  reset` — synchronous, active-high.
- `interrupt  in  1` — flush of all in-flight (non-retired) instructions.
- `alloc_req  in  1` — dispatch requests one tag this cycle.
- `alloc_valid  out  1` — a free tag is available (`count != 0`).
- `alloc_tag  out  TAG_W` — tag at the head; meaningful when `alloc_valid` is high.
- `retire_en  in  1` — ROB head retires this cycle.
- `retire_t_valid  in  1` — the retiring instruction allocated a tag (it has a destination).
- `retire_t_old  in  TAG_W` — previous mapping of the retiring destination; this tag is freed.
- `retire_t_old_valid  in  1` — `retire_t_old` is valid.
- `free_count  out  $clog2(FL_SZ)+1` — current number of free tags.
- `overflow_err  out  1` — sticky; set when a free is attempted while full.

## Operation
- Storage: circular buffer `fl[FL_SZ]` of tags, plus pointers `head`, `arch_head` and `tail` (each `$clog2(FL_SZ)` bits, wrapping naturally), and `count`.
- Reset state:
  - `fl[i] = N_ARCH + i` for all `i`.
  - `head = arch_head = tail = 0`; `count = FL_SZ`.
  - `overflow_err = 0`.
  - Resulting outputs: `alloc_valid = 1`, `alloc_tag = N_ARCH`, `free_count = FL_SZ`.
- Allocate (`alloc_fire = alloc_req && count != 0 && !interrupt`):
  - `head <= head + 1`.
  - If `count == 0`, `alloc_req` is ignored: no pointer move, no error.
- Free (`free_fire = retire_en && retire_t_old_valid`):
  - `fl[tail] <= retire_t_old`; `tail <= tail + 1`.
  - If `count == FL_SZ` and no same-cycle `alloc_fire`: the write is dropped and `overflow_err <= 1`.
- Architectural head: `arch_head <= arch_head + 1` when `retire_en && retire_t_valid`. This holds because allocation and retirement are both in program order.
- Count update:
  - `+1` on `free_fire` alone.
  - `-1` on `alloc_fire` alone.
  - Unchanged on both or neither.
- Interrupt (`interrupt` high, `reset` low):
  - Retire side of the same cycle still commits: the free and the `arch_head` advance happen.
  - `head <= arch_head_next`, the post-retire value of `arch_head`.
  - `count <= FL_SZ`.
  - `alloc_req` is ignored.
- `reset` has priority over `interrupt` and restores the full reset state, including the buffer contents.

## Timing
- `alloc_valid`, `alloc_tag` and `free_count` are combinational from registers only; there is no combinational path from any input.
- Allocation is zero-latency: dispatch samples `alloc_tag` in the same cycle it asserts `alloc_req`. The next tag is visible the following cycle.
- A freed tag becomes allocatable one cycle after `retire_en`; there is no same-cycle bypass.
- Empty:
  - `alloc_valid = 0`, which stalls dispatch.
  - A free in that cycle makes `alloc_valid = 1` next cycle, with `alloc_tag` equal to the freed tag.
- Full with simultaneous alloc + free: legal. `count` stays `FL_SZ`; the write lands at `tail` while `head` advances.
- Wrap-around: pointers roll `FL_SZ-1 -> 0` with no special casing.
- Invariant: after an interrupt, `head == arch_head` and `count == FL_SZ`.

## Test plan
- **Reset drain:** after reset, assert `alloc_req` for 32 cycles.
  - Tags 32..63 are returned in order.
  - `free_count` goes 32 -> 0 and then `alloc_valid = 0`.
  - A 33rd request leaves `head` unchanged.
- **Free and reuse when empty:** with the list empty, retire with `retire_t_old = 5`.
  - Next cycle: `alloc_valid = 1`, `alloc_tag = 5`, `free_count = 1`.
- **Simultaneous alloc + free at full:** at reset state, `alloc_req = 1` with a free of tag 7 in the same cycle.
  - `free_count` stays 32 and `overflow_err = 0`.
  - After 31 further allocs, the 32nd alloc returns 7 (write landed at slot 0 after wrap).
- **Flush recovery:**
  - Allocate 10 tags (32..41) and retire 3 of them with `t_valid`, each freeing `t_old` 1, 2, 3.
  - Then assert `interrupt`.
  - Next cycle: `free_count = 32`, `alloc_tag = 35`.
  - The following allocs return 36..63, then 1, 2, 3.
- **Interrupt with same-cycle retire:** assert `interrupt` together with a retire (`t_valid = 1`, `t_old = 9`).
  - `arch_head` advances first, so `head` equals the incremented `arch_head`.
  - Tag 9 is present at the old `tail`.
  - `free_count = 32`.
- **Overflow / reset priority:**
  - At full, free tag 4 with no alloc: `overflow_err = 1`, `free_count` stays 32, and 4 is not stored.
  - Assert `reset` and `interrupt` together: the full reset state is restored and `overflow_err = 0`.
